// File: rtl/multi_debounce_pkg.sv
// Shared helpers for the multi-channel debouncer: counter sizing and
// parameter legality used at elaboration time.
package multi_debounce_pkg;

  // Bits needed to hold any value in 0..v inclusive.
  function automatic int cnt_width(input int v);
    return $clog2(v + 1);
  endfunction

  // Every count-type parameter of this block must be at least one.
  function automatic bit param_ok(input int v);
    return v >= 1;
  endfunction

endpackage

// File: rtl/multi_debounce_if.sv
// Button bundle between raw board inputs and the debouncer.
// No handshake: btn_in is a free-running raw level; btn_out is a level;
// btn_rise/fall/long/repeat and sample_tick are single-cycle strobes with
// no ready/backpressure, consumers must sample them every cycle.
interface multi_debounce_if #(
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] btn_out;
  logic [CHANNELS-1:0] btn_rise;
  logic [CHANNELS-1:0] btn_fall;
  logic [CHANNELS-1:0] btn_long;
  logic [CHANNELS-1:0] btn_repeat;
  logic                sample_tick;

  modport master (
    output btn_in,
    input  btn_out, btn_rise, btn_fall, btn_long, btn_repeat, sample_tick
  );

  modport slave (
    input  btn_in,
    output btn_out, btn_rise, btn_fall, btn_long, btn_repeat, sample_tick
  );
endinterface

// File: rtl/multi_debounce_channel.sv
// One debounce channel: 2-flop synchroniser, stable-sample counter,
// registered edge pulses and hold/auto-repeat pulses.
module multi_debounce_channel
  import multi_debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 10,
  parameter int LONG_SAMPLES   = 500,
  parameter int REPEAT_SAMPLES = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int SW = cnt_width(STABLE_SAMPLES);
  localparam int HW = cnt_width(LONG_SAMPLES);
  localparam int RW = cnt_width(REPEAT_SAMPLES);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_SAMPLES);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(LONG_SAMPLES);
  localparam logic [RW-1:0] REP_MAX    = RW'(REPEAT_SAMPLES);

  logic          sync_a;
  logic          sync_b;
  logic [SW-1:0] stable_cnt;
  logic [HW-1:0] hold_cnt;
  logic [RW-1:0] rep_cnt;
  logic [SW-1:0] stable_inc;
  logic [HW-1:0] hold_inc;
  logic [RW-1:0] rep_inc;
  logic          toggle;

  assign stable_inc = stable_cnt + 1'b1;
  assign hold_inc   = hold_cnt + 1'b1;
  assign rep_inc    = rep_cnt + 1'b1;
  // The level flips on this edge: a tick that completes the run of differing samples.
  assign toggle     = tick && (sync_b != level) && (stable_inc == STABLE_MAX);

  // Two-flop synchroniser for the asynchronous raw input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Stable-sample counter, debounced level and its edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
      rise       <= 1'b0;
      fall       <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (tick) begin
        if (sync_b == level) begin
          stable_cnt <= '0;
        end else if (toggle) begin
          stable_cnt <= '0;
          level      <= ~level;
          rise       <= ~level;
          fall       <= level;
        end else begin
          stable_cnt <= stable_inc;
        end
      end
    end
  end

  // Hold counting: one long pulse per press, then periodic repeat pulses.
  // The rising tick is not a hold sample, and the falling tick clears silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt     <= '0;
      rep_cnt      <= '0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      if (!level || toggle) begin
        hold_cnt <= '0;
        rep_cnt  <= '0;
      end else if (tick) begin
        if (hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_inc;
          if (hold_inc == HOLD_MAX) begin
            long_pulse <= 1'b1;
            rep_cnt    <= '0;
          end
        end else if (rep_inc == REP_MAX) begin
          repeat_pulse <= 1'b1;
          rep_cnt      <= '0;
        end else begin
          rep_cnt <= rep_inc;
        end
      end
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer top: shared sample prescaler feeding one
// multi_debounce_channel per input bit.
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CLK_DIV        = 100000,
  parameter int STABLE_SAMPLES = 10,
  parameter int LONG_SAMPLES   = 500,
  parameter int REPEAT_SAMPLES = 100
) (
  input  logic             clk,
  input  logic             rst,
  multi_debounce_if.slave  bus
);
  localparam int PW = cnt_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  if (!param_ok(CHANNELS))       begin : g_bad_channels $error("CHANNELS must be >= 1"); end
  if (!param_ok(CLK_DIV))        begin : g_bad_clk_div  $error("CLK_DIV must be >= 1"); end
  if (!param_ok(STABLE_SAMPLES)) begin : g_bad_stable   $error("STABLE_SAMPLES must be >= 1"); end
  if (!param_ok(LONG_SAMPLES))   begin : g_bad_long     $error("LONG_SAMPLES must be >= 1"); end
  if (!param_ok(REPEAT_SAMPLES)) begin : g_bad_repeat   $error("REPEAT_SAMPLES must be >= 1"); end

  logic [PW-1:0]       presc_cnt;
  logic [PW-1:0]       presc_next;
  logic                tick;
  logic [CHANNELS-1:0] out_v;
  logic [CHANNELS-1:0] rise_v;
  logic [CHANNELS-1:0] fall_v;
  logic [CHANNELS-1:0] long_v;
  logic [CHANNELS-1:0] rep_v;

  // Prescaler wraps 0..CLK_DIV-1.
  always_comb begin
    presc_next = (presc_cnt == PRESC_LAST) ? '0 : presc_cnt + 1'b1;
  end

  // Tick is registered so it is high exactly while the count sits at CLK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_cnt <= '0;
      tick      <= 1'b0;
    end else begin
      presc_cnt <= presc_next;
      tick      <= (presc_next == PRESC_LAST);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    multi_debounce_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .LONG_SAMPLES   (LONG_SAMPLES),
      .REPEAT_SAMPLES (REPEAT_SAMPLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .raw          (bus.btn_in[i]),
      .level        (out_v[i]),
      .rise         (rise_v[i]),
      .fall         (fall_v[i]),
      .long_pulse   (long_v[i]),
      .repeat_pulse (rep_v[i])
    );
  end

  assign bus.btn_out     = out_v;
  assign bus.btn_rise    = rise_v;
  assign bus.btn_fall    = fall_v;
  assign bus.btn_long    = long_v;
  assign bus.btn_repeat  = rep_v;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_multi_debounce.sv
// Bench for multi_debounce: directed scenarios then random bouncing, with a
// cycle-level reference model built from the behavioural rules.
module tb_multi_debounce;
  localparam int CH  = 4;
  localparam int DIV = 4;
  localparam int STB = 3;
  localparam int LNG = 8;
  localparam int REP = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_debounce_if #(.CHANNELS(CH)) bus ();

  multi_debounce #(
    .CHANNELS       (CH),
    .CLK_DIV        (DIV),
    .STABLE_SAMPLES (STB),
    .LONG_SAMPLES   (LNG),
    .REPEAT_SAMPLES (REP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [CH-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_long, m_rep;
  logic          m_tick;
  int            m_pcnt;
  int            m_run  [CH];
  int            m_hold [CH];

  // observed pulse counters for directed scenarios
  int n_rise [CH];
  int n_fall [CH];
  int n_long [CH];
  int n_rep  [CH];

  task automatic check_bits(input string tag, input logic [CH-1:0] got, input logic [CH-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %b exp %b", tag, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < CH; i++) begin
      n_rise[i] = 0; n_fall[i] = 0; n_long[i] = 0; n_rep[i] = 0;
    end
  endtask

  // Model: a level change needs STB consecutive differing samples; hold
  // samples are counted from the tick after the rise; long at hold==LNG,
  // repeat every REP hold samples beyond that.
  task automatic model_edge(input logic [CH-1:0] in_now, input logic rst_now);
    if (rst_now) begin
      m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0;
      m_long = '0; m_rep = '0; m_tick = 1'b0; m_pcnt = 0;
      for (int i = 0; i < CH; i++) begin
        m_run[i] = 0; m_hold[i] = 0;
      end
    end else begin
      m_rise = '0; m_fall = '0; m_long = '0; m_rep = '0;
      for (int i = 0; i < CH; i++) begin
        if (m_tick) begin
          if (m_s2[i] != m_out[i]) m_run[i]++;
          else m_run[i] = 0;
          if (m_run[i] == STB) begin
            m_run[i] = 0;
            m_out[i] = ~m_out[i];
            if (m_out[i]) m_rise[i] = 1'b1;
            else begin
              m_fall[i] = 1'b1;
              m_hold[i] = 0;
            end
          end else if (m_out[i]) begin
            m_hold[i]++;
            if (m_hold[i] == LNG) m_long[i] = 1'b1;
            if (m_hold[i] > LNG && ((m_hold[i] - LNG) % REP) == 0) m_rep[i] = 1'b1;
          end
        end
      end
      m_s2   = m_s1;
      m_s1   = in_now;
      m_pcnt = (m_pcnt + 1) % DIV;
      m_tick = (m_pcnt == DIV - 1);
    end
  endtask

  // driver: advance one clock, update model, compare every output
  task automatic step();
    logic [CH-1:0] in_now;
    logic          rst_now;
    in_now  = bus.btn_in;
    rst_now = rst;
    @(posedge clk);
    model_edge(in_now, rst_now);
    #1;
    check_bits("btn_out",     bus.btn_out,    m_out);
    check_bits("btn_rise",    bus.btn_rise,   m_rise);
    check_bits("btn_fall",    bus.btn_fall,   m_fall);
    check_bits("btn_long",    bus.btn_long,   m_long);
    check_bits("btn_repeat",  bus.btn_repeat, m_rep);
    check_bits("sample_tick", CH'(bus.sample_tick), CH'(m_tick));
    check_bits("rise_fall_excl", bus.btn_rise & bus.btn_fall, '0);
    for (int i = 0; i < CH; i++) begin
      n_rise[i] += int'(bus.btn_rise[i]);
      n_fall[i] += int'(bus.btn_fall[i]);
      n_long[i] += int'(bus.btn_long[i]);
      n_rep[i]  += int'(bus.btn_repeat[i]);
    end
  endtask

  // bounded wait for a channel level; timeout counts as a failure
  task automatic wait_level(input int ch, input logic val, output int lat);
    lat = 0;
    while (bus.btn_out[ch] !== val && lat < 80) begin
      step();
      lat++;
    end
    checks++;
    assert (bus.btn_out[ch] === val) else begin
      errors++;
      $error("FAIL wait_level ch%0d got %b exp %b after %0d cycles", ch, bus.btn_out[ch], val, lat);
    end
  endtask

  initial begin
    int lat;
    int seg;
    logic [CH-1:0] first_rise;
    bus.btn_in = '0;
    clear_counts();

    // reset
    rst = 1'b1;
    step();
    step();
    check_bits("reset_out", bus.btn_out, '0);
    rst = 1'b0;
    repeat (6) step();

    // 1: clean press on channel 0
    clear_counts();
    bus.btn_in = 4'b0001;
    wait_level(0, 1'b1, lat);
    check_int("press_latency_in_range", int'(lat >= 2 + (STB - 1) * DIV + 1 && lat <= 2 + DIV + (STB - 1) * DIV), 1);
    repeat (10) step();
    check_int("press_rise_cnt", n_rise[0], 1);
    check_bits("press_levels", bus.btn_out, 4'b0001);
    check_int("press_other_rise", n_rise[1] + n_rise[2] + n_rise[3], 0);

    // 2: glitch rejection on channel 1 (two samples, then a one-cycle spike)
    clear_counts();
    bus.btn_in[1] = 1'b1;
    repeat (2 * DIV) step();
    bus.btn_in[1] = 1'b0;
    repeat (20) step();
    bus.btn_in[1] = 1'b1;
    step();
    bus.btn_in[1] = 1'b0;
    repeat (20) step();
    check_int("glitch_rise_cnt", n_rise[1], 0);
    check_bits("glitch_levels", bus.btn_out, 4'b0001);

    // 3: release channel 0
    clear_counts();
    bus.btn_in[0] = 1'b0;
    wait_level(0, 1'b0, lat);
    check_int("release_latency_in_range", int'(lat >= 2 + (STB - 1) * DIV + 1 && lat <= 2 + DIV + (STB - 1) * DIV), 1);
    repeat (10) step();
    check_int("release_fall_cnt", n_fall[0], 1);
    check_int("release_rise_cnt", n_rise[0], 0);

    // 4: long press and auto-repeat on channel 2 over 30 hold ticks
    bus.btn_in[2] = 1'b1;
    wait_level(2, 1'b1, lat);
    clear_counts();
    repeat (30 * DIV) step();
    check_int("long_cnt", n_long[2], 1);
    check_int("repeat_cnt", n_rep[2], 5);
    bus.btn_in[2] = 1'b0;
    wait_level(2, 1'b0, lat);
    clear_counts();
    repeat (40) step();
    check_int("after_release_long", n_long[2], 0);
    check_int("after_release_repeat", n_rep[2], 0);

    // 5: reset while channel 3 is held
    bus.btn_in[3] = 1'b1;
    wait_level(3, 1'b1, lat);
    repeat (5) step();
    clear_counts();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_bits("midrst_out", bus.btn_out, '0);
    check_int("midrst_fall", n_fall[3], 0);
    wait_level(3, 1'b1, lat);
    repeat (10) step();
    check_int("midrst_rise_cnt", n_rise[3], 1);
    check_int("midrst_fall_cnt", n_fall[3], 0);

    // 6: all channels pressed in the same cycle
    bus.btn_in = '0;
    wait_level(3, 1'b0, lat);
    repeat (10) step();
    clear_counts();
    bus.btn_in = 4'b1111;
    first_rise = '0;
    for (int k = 0; k < 40 && first_rise == '0; k++) begin
      step();
      first_rise = bus.btn_rise;
    end
    check_bits("simul_rise", first_rise, 4'b1111);
    repeat (10) step();
    check_bits("simul_levels", bus.btn_out, 4'b1111);

    // random bouncing, long holds and occasional resets
    for (int s = 0; s < 150; s++) begin
      bus.btn_in = CH'($urandom);
      seg = ($urandom_range(0, 3) == 0) ? $urandom_range(40, 200) : $urandom_range(1, 12);
      rst = ($urandom_range(0, 39) == 0);
      step();
      rst = 1'b0;
      repeat (seg) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
